// File: rtl/lcd_st_pkg.sv
// Shared types for the LCD Avalon-ST packet arbiter: FSM states, payload layout
// and the saturating orphan-counter helper.
package lcd_st_pkg;

   localparam int unsigned ST_DATA_W  = 64;
   localparam int unsigned ST_EMPTY_W = 3;
   localparam int unsigned PAYLOAD_W  = ST_DATA_W + 2 + ST_EMPTY_W;

   typedef enum logic [1:0] {
      IDLE,
      GRANT0,
      GRANT1
   } state_e;

   typedef struct packed {
      logic [ST_DATA_W-1:0]  data;
      logic                  sop;
      logic                  eop;
      logic [ST_EMPTY_W-1:0] empty;
   } payload_t;

   function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] n);
      logic [8:0] s;
      s = {1'b0, a} + {7'b0, n};
      return s[8] ? 8'hFF : s[7:0];
   endfunction

endpackage

// File: rtl/lcd_st_skid2.sv
// Two-entry ready/valid register buffer; entry 0 drives the output and stays
// stable until popped, entry 1 absorbs the beat that arrives during a stall.
module lcd_st_skid2
   import lcd_st_pkg::*;
#(
   parameter int unsigned W = PAYLOAD_W
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   logic [W-1:0] e0_q, e0_d, e1_q, e1_d;
   logic         v0_q, v0_d, v1_q, v1_d;
   logic         pop;

   always_comb begin
      pop      = v0_q & out_ready;
      in_ready = ~v1_q | out_ready;
      // Shift first, then place the incoming beat in the lowest free slot.
      e0_d = pop ? e1_q : e0_q;
      v0_d = pop ? v1_q : v0_q;
      e1_d = e1_q;
      v1_d = pop ? 1'b0 : v1_q;
      if (in_valid & in_ready) begin
         if (!v0_d) begin
            e0_d = in_data;
            v0_d = 1'b1;
         end else begin
            e1_d = in_data;
            v1_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         e0_q <= '0;
         e1_q <= '0;
         v0_q <= 1'b0;
         v1_q <= 1'b0;
      end else begin
         e0_q <= e0_d;
         e1_q <= e1_d;
         v0_q <= v0_d;
         v1_q <= v1_d;
      end
   end

   assign out_valid = v0_q;
   assign out_data  = e0_q;

endmodule

// File: rtl/lcd_st_packet_arbiter.sv
// Packet-granular round-robin arbiter sharing the LCD pixel FIFO path between
// two 64-bit Avalon-ST sources, with debug packet and orphan-beat counters.
module lcd_st_packet_arbiter
   import lcd_st_pkg::*;
#(
   parameter int unsigned DATA_W  = ST_DATA_W,
   parameter int unsigned EMPTY_W = ST_EMPTY_W,
   parameter int unsigned CNT_W   = 16
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               enable,
   output logic               in0_ready,
   input  logic               in0_valid,
   input  logic [DATA_W-1:0]  in0_data,
   input  logic               in0_startofpacket,
   input  logic               in0_endofpacket,
   input  logic [EMPTY_W-1:0] in0_empty,
   output logic               in1_ready,
   input  logic               in1_valid,
   input  logic [DATA_W-1:0]  in1_data,
   input  logic               in1_startofpacket,
   input  logic               in1_endofpacket,
   input  logic [EMPTY_W-1:0] in1_empty,
   input  logic               out_ready,
   output logic               out_valid,
   output logic [DATA_W-1:0]  out_data,
   output logic               out_startofpacket,
   output logic               out_endofpacket,
   output logic [EMPTY_W-1:0] out_empty,
   output logic               busy,
   output logic               grant_idx,
   output logic [CNT_W-1:0]   pkt_count0,
   output logic [CNT_W-1:0]   pkt_count1,
   output logic [7:0]         orphan_count
);

   localparam int unsigned PW = DATA_W + 2 + EMPTY_W;

   state_e           state_q, state_d;
   logic             grant_idx_q, grant_idx_d;
   logic [CNT_W-1:0] pkt_count0_q, pkt_count0_d;
   logic [CNT_W-1:0] pkt_count1_q, pkt_count1_d;
   logic [7:0]       orphan_count_q, orphan_count_d;

   logic          skid_in_valid, skid_in_ready;
   logic [PW-1:0] skid_in_data, skid_out_data;
   logic          cand0, cand1, drain0, drain1, acc0, acc1, win;

   always_comb begin
      cand0  = in0_valid & in0_startofpacket & enable;
      cand1  = in1_valid & in1_startofpacket & enable;
      drain0 = (state_q == IDLE) & in0_valid & ~in0_startofpacket;
      drain1 = (state_q == IDLE) & in1_valid & ~in1_startofpacket;
      acc0   = (state_q == GRANT0) & in0_valid & skid_in_ready;
      acc1   = (state_q == GRANT1) & in1_valid & skid_in_ready;
      // Readies are forced low while reset is held so no beat is consumed.
      in0_ready = reset_n & (drain0 | ((state_q == GRANT0) & skid_in_ready));
      in1_ready = reset_n & (drain1 | ((state_q == GRANT1) & skid_in_ready));
      skid_in_valid = acc0 | acc1;
      skid_in_data  = (state_q == GRANT1)
                    ? {in1_data, in1_startofpacket, in1_endofpacket, in1_empty}
                    : {in0_data, in0_startofpacket, in0_endofpacket, in0_empty};
      win = (cand0 & cand1) ? ~grant_idx_q : cand1;

      state_d        = state_q;
      grant_idx_d    = grant_idx_q;
      pkt_count0_d   = pkt_count0_q;
      pkt_count1_d   = pkt_count1_q;
      orphan_count_d = sat_add8(orphan_count_q, {1'b0, drain0} + {1'b0, drain1});
      case (state_q)
         IDLE: begin
            if (cand0 | cand1) begin
               state_d     = win ? GRANT1 : GRANT0;
               grant_idx_d = win;
            end
         end
         GRANT0: begin
            if (acc0 & in0_endofpacket) begin
               state_d      = IDLE;
               pkt_count0_d = pkt_count0_q + CNT_W'(1);
            end
         end
         GRANT1: begin
            if (acc1 & in1_endofpacket) begin
               state_d      = IDLE;
               pkt_count1_d = pkt_count1_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= IDLE;
         grant_idx_q    <= 1'b1;
         pkt_count0_q   <= '0;
         pkt_count1_q   <= '0;
         orphan_count_q <= '0;
      end else begin
         state_q        <= state_d;
         grant_idx_q    <= grant_idx_d;
         pkt_count0_q   <= pkt_count0_d;
         pkt_count1_q   <= pkt_count1_d;
         orphan_count_q <= orphan_count_d;
      end
   end

   lcd_st_skid2 #(.W(PW)) u_skid (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (skid_in_valid),
      .in_ready  (skid_in_ready),
      .in_data   (skid_in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (skid_out_data)
   );

   assign {out_data, out_startofpacket, out_endofpacket, out_empty} = skid_out_data;
   assign busy         = (state_q != IDLE);
   assign grant_idx    = grant_idx_q;
   assign pkt_count0   = pkt_count0_q;
   assign pkt_count1   = pkt_count1_q;
   assign orphan_count = orphan_count_q;

endmodule
